// File: rtl/pe_row_feeder_pkg.sv
// pe_row_feeder_pkg
// Shared definitions for the PE row feeder:
//   state_t  - feeder FSM states (IDLE, LOAD_W, STREAM)
//   K        - number of taps in one PE row
//   cnt_w()  - bit width of a counter that spans 0..n-1 (never below 1)
package pe_row_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      STREAM = 2'd2
   } state_t;

   localparam int K = 5;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pe_row_feeder_valid.sv
// valid_delay
// Fixed-depth 1-bit delay line used to line up a valid flag with the
// output of a pipelined datapath. It shifts every cycle and never stalls.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears the whole line
//   din   - flag entering the line
//   dout  - din delayed by DEPTH cycles
module valid_delay #(
   parameter int DEPTH = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr;

   generate
      if (DEPTH == 1) begin : g_one
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sr <= '0;
            else        sr <= din;
         end
      end else begin : g_multi
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sr <= '0;
            else        sr <= {sr[DEPTH-2:0], din};
         end
      end
   endgenerate

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/pe_row_feeder.sv
// pe_row_feeder
// Input-side driver for a five-tap PE row. It loads one filter row of
// weights (and, with FEEDER_BIAS_EN defined, a sixth word used as bias),
// then streams raster pixels through a 5-pixel sliding window that never
// straddles an image row. arr_valid marks the cycles where the PE row's Po
// output carries a finished dot product.
// Build option: FEEDER_BIAS_EN - 6-word load; the 6th word drives Po.
//                                 When undefined Po is constant 0.
// Handshakes: a transfer happens on a rising edge where valid && ready.
//   ready is a registered state decode; valid may rise at any time and the
//   producer holds data until the transfer. Outputs have no back-pressure.
// Ports:
//   clk, rst (async active-low)
//   start                 - begin a weight load (only honoured in IDLE)
//   w_valid/w_data/w_ready - weight port, tap 0 first
//   px_valid/px_data/px_ready - raster pixel port
//   Wo0..Wo4, Io0..Io4, Po - PE row inputs (weights, window, seed)
//   win_valid, arr_valid  - window complete / PE row result valid
//   row_done, frame_done  - end-of-row / end-of-frame pulses
//   dbg_state             - current FSM state
module pe_row_feeder
   import pe_row_feeder_pkg::*;
#(
   parameter int M      = 32,
   parameter int N      = 0,
   parameter int IMG_W  = 32,
   parameter int ROWS   = 28,
   parameter int PE_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         w_valid,
   input  logic [M-1:0] w_data,
   output logic         w_ready,
   input  logic         px_valid,
   input  logic [M-1:0] px_data,
   output logic         px_ready,
   output logic [M-1:0] Wo0,
   output logic [M-1:0] Wo1,
   output logic [M-1:0] Wo2,
   output logic [M-1:0] Wo3,
   output logic [M-1:0] Wo4,
   output logic [M-1:0] Io0,
   output logic [M-1:0] Io1,
   output logic [M-1:0] Io2,
   output logic [M-1:0] Io3,
   output logic [M-1:0] Io4,
   output logic [M-1:0] Po,
   output logic         win_valid,
   output logic         arr_valid,
   output logic         row_done,
   output logic         frame_done,
   output state_t       dbg_state
);

   localparam int CW = cnt_w(IMG_W);
   localparam int RW = cnt_w(ROWS);
`ifdef FEEDER_BIAS_EN
   localparam int NW = K + 1;
`else
   localparam int NW = K;
`endif
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_WIN   = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
   localparam logic [2:0]    WCNT_LAST = 3'(NW - 1);

   generate
      if (IMG_W < K || ROWS < 1 || PE_LAT < 1 || N >= M) begin : g_bad_param
         $error("pe_row_feeder: illegal parameter combination");
      end
   endgenerate

   state_t         state;
   logic [2:0]     wcnt;
   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   logic [M-1:0]   wr [K];
   logic [M-1:0]   io [K];
   logic           w_hs;
   logic           px_hs;

   assign w_hs  = w_valid && w_ready;
   assign px_hs = px_valid && px_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wcnt       <= '0;
         col        <= '0;
         row        <= '0;
         w_ready    <= 1'b0;
         px_ready   <= 1'b0;
         win_valid  <= 1'b0;
         row_done   <= 1'b0;
         frame_done <= 1'b0;
         for (int i = 0; i < K; i++) begin
            wr[i] <= '0;
            io[i] <= '0;
         end
      end else begin
         win_valid  <= 1'b0;
         row_done   <= 1'b0;
         frame_done <= 1'b0;

         // The last window of a row is shown together with row_done; the
         // window empties one cycle later so a new row starts from zeros.
         if (row_done) begin
            for (int i = 0; i < K; i++) io[i] <= '0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state   <= LOAD_W;
                  w_ready <= 1'b1;
                  wcnt    <= '0;
               end
            end

            LOAD_W: begin
               if (w_hs) begin
                  if (wcnt < 3'(K)) wr[wcnt] <= w_data;
                  if (wcnt == WCNT_LAST) begin
                     state    <= STREAM;
                     w_ready  <= 1'b0;
                     px_ready <= 1'b1;
                     wcnt     <= '0;
                  end else begin
                     wcnt <= wcnt + 3'd1;
                  end
               end
            end

            STREAM: begin
               if (px_hs) begin
                  // row_done high here means this is column 0 of a new row:
                  // shift in zeros instead of the previous row's pixels.
                  for (int i = 0; i < K - 1; i++)
                     io[i] <= row_done ? '0 : io[i+1];
                  io[K-1]   <= px_data;
                  win_valid <= (col >= COL_WIN);
                  if (col == COL_LAST) begin
                     col      <= '0;
                     row_done <= 1'b1;
                     if (row == ROW_LAST) begin
                        row        <= '0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                        px_ready   <= 1'b0;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end

            default: begin
               state    <= IDLE;
               w_ready  <= 1'b0;
               px_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef FEEDER_BIAS_EN
   logic [M-1:0] bias;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         bias <= '0;
      else if (state == LOAD_W && w_hs && wcnt == 3'(K))
         bias <= w_data;
   end

   assign Po = bias;
`else
   assign Po = '0;
`endif

   assign Wo0 = wr[0];
   assign Wo1 = wr[1];
   assign Wo2 = wr[2];
   assign Wo3 = wr[3];
   assign Wo4 = wr[4];
   assign Io0 = io[0];
   assign Io1 = io[1];
   assign Io2 = io[2];
   assign Io3 = io[3];
   assign Io4 = io[4];
   assign dbg_state = state;

   valid_delay #(.DEPTH(K * PE_LAT)) u_arr_delay (
      .clk   (clk),
      .rst_n (rst),
      .din   (win_valid),
      .dout  (arr_valid)
   );

endmodule

// File: tb/tb_pe_row_feeder.sv
module tb_pe_row_feeder;
   import pe_row_feeder_pkg::*;

   localparam int M      = 32;
   localparam int IMG_W  = 8;
   localparam int ROWS   = 2;
   localparam int PE_LAT = 1;
   localparam int LAT    = 5 * PE_LAT;
   localparam int NPX    = IMG_W * ROWS;
`ifdef FEEDER_BIAS_EN
   localparam int NW = 6;
`else
   localparam int NW = 5;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         w_valid;
   logic [M-1:0] w_data;
   logic         w_ready;
   logic         px_valid;
   logic [M-1:0] px_data;
   logic         px_ready;
   logic [M-1:0] Wo0, Wo1, Wo2, Wo3, Wo4;
   logic [M-1:0] Io0, Io1, Io2, Io3, Io4;
   logic [M-1:0] Po;
   logic         win_valid, arr_valid, row_done, frame_done;
   state_t       dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   int win_count;
   logic [M-1:0] exp_po = '0;
   logic [M-1:0] exp_w [5];

   always #5 clk = ~clk;

   pe_row_feeder #(.M(M), .N(0), .IMG_W(IMG_W), .ROWS(ROWS), .PE_LAT(PE_LAT)) dut (
      .clk(clk), .rst(rst), .start(start),
      .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
      .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
      .Wo0(Wo0), .Wo1(Wo1), .Wo2(Wo2), .Wo3(Wo3), .Wo4(Wo4),
      .Io0(Io0), .Io1(Io1), .Io2(Io2), .Io3(Io3), .Io4(Io4),
      .Po(Po), .win_valid(win_valid), .arr_valid(arr_valid),
      .row_done(row_done), .frame_done(frame_done), .dbg_state(dbg_state)
   );

   function automatic logic [M-1:0] get_io(input int i);
      case (i)
         0: return Io0;
         1: return Io1;
         2: return Io2;
         3: return Io3;
         default: return Io4;
      endcase
   endfunction

   function automatic logic [M-1:0] get_wo(input int i);
      case (i)
         0: return Wo0;
         1: return Wo1;
         2: return Wo2;
         3: return Wo3;
         default: return Wo4;
      endcase
   endfunction

   // Bench time invariant between tasks: 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; w_valid = 1'b0; w_data = '0;
      px_valid = 1'b0; px_data = '0;
      tick();
      n_cmp++;
      if ({Wo0, Wo1, Wo2, Wo3, Wo4, Io0, Io1, Io2, Io3, Io4, Po} !== '0) begin
         n_err++; $display("FAIL reset_data: got nonzero data outputs, expected all 0");
      end
      n_cmp++;
      if ({w_ready, px_ready, win_valid, arr_valid, row_done, frame_done} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {w_ready, px_ready, win_valid, arr_valid, row_done, frame_done});
      end
      n_cmp++;
      if (dbg_state !== IDLE) begin
         n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_weight_load(input bit rand_w);
      logic [M-1:0] wv [6];
      for (int i = 0; i < 6; i++)
         wv[i] = rand_w ? M'($urandom) : ((i < 5) ? M'(i + 1) : M'(7));
      n_cmp++;
      if (w_ready !== 1'b0 || dbg_state !== IDLE) begin
         n_err++; $display("FAIL load_pre_idle: got w_ready=%b state=%0d expected 0/IDLE", w_ready, dbg_state);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if (dbg_state !== LOAD_W) begin
         n_err++; $display("FAIL load_state: got %0d expected %0d", dbg_state, LOAD_W);
      end
      for (int i = 0; i < NW; i++) begin
         if (rand_w && $urandom_range(0, 1) == 1) begin
            w_valid = 1'b0;
            tick();
         end
         w_valid = 1'b1;
         w_data  = wv[i];
         n_cmp++;
         if (w_ready !== 1'b1) begin
            n_err++; $display("FAIL load_w_ready word %0d: got %b expected 1", i, w_ready);
         end
         tick();
      end
      w_valid = 1'b0;
      w_data  = '0;
      n_cmp++;
      if (w_ready !== 1'b0 || px_ready !== 1'b1) begin
         n_err++; $display("FAIL load_exit: got w_ready=%b px_ready=%b expected 0/1", w_ready, px_ready);
      end
      for (int i = 0; i < 5; i++) begin
         exp_w[i] = wv[i];
         n_cmp++;
         if (get_wo(i) !== wv[i]) begin
            n_err++; $display("FAIL load_Wo%0d: got %0h expected %0h", i, get_wo(i), wv[i]);
         end
      end
`ifdef FEEDER_BIAS_EN
      exp_po = wv[5];
`else
      exp_po = '0;
`endif
      n_cmp++;
      if (Po !== exp_po) begin
         n_err++; $display("FAIL load_Po: got %0h expected %0h", Po, exp_po);
      end
   endtask

   // mode 0: directed pixels (row r, col c -> 10*(r+1)+c), always valid
   // mode 1: random pixels, px_valid toggling 1/0
   // mode 2: random pixels, random px_valid
   task automatic run_frame(input int mode);
      logic [M-1:0] pix [NPX];
      logic [M-1:0] ew [5];
      bit hist [$];
      int p, cyc, col;
      bit v, acc, prev_end, e_wv, e_rd, e_fd, exp_av;
      for (int i = 0; i < NPX; i++)
         pix[i] = (mode == 0) ? M'(10 * (i / IMG_W + 1) + i % IMG_W) : M'($urandom);
      for (int i = 0; i < 5; i++) ew[i] = '0;
      for (int i = 0; i < LAT; i++) hist.push_back(1'b0);
      p = 0; cyc = 0; prev_end = 1'b0; win_count = 0;
      while (p < NPX && cyc < 500) begin
         v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         px_valid = v;
         px_data  = v ? pix[p] : M'($urandom);
         start    = (cyc == 3);
         n_cmp++;
         if (px_ready !== 1'b1 || w_ready !== 1'b0) begin
            n_err++; $display("FAIL stream_ready cyc %0d: got px_ready=%b w_ready=%b expected 1/0", cyc, px_ready, w_ready);
         end
         acc = v;
         tick();
         start = 1'b0;
         if (acc) begin
            col  = p % IMG_W;
            e_wv = (col >= 4);
            e_rd = (col == IMG_W - 1);
            e_fd = (p == NPX - 1);
            // Window = last five pixels of the current row, zero-padded.
            for (int i = 0; i < 5; i++)
               ew[i] = (p - 4 + i >= p - col) ? pix[p - 4 + i] : '0;
            p++;
         end else begin
            e_wv = 1'b0; e_rd = 1'b0; e_fd = 1'b0;
            if (prev_end) for (int i = 0; i < 5; i++) ew[i] = '0;
         end
         prev_end = acc && e_rd;
         hist.push_back(e_wv);
         exp_av = hist.pop_front();
         n_cmp++;
         if ({win_valid, row_done, frame_done} !== {e_wv, e_rd, e_fd}) begin
            n_err++;
            $display("FAIL stream_flags pix %0d: got wv/rd/fd=%b%b%b expected %b%b%b",
                     p, win_valid, row_done, frame_done, e_wv, e_rd, e_fd);
         end
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (get_io(i) !== ew[i]) begin
               n_err++; $display("FAIL stream_Io%0d pix %0d: got %0h expected %0h", i, p, get_io(i), ew[i]);
            end
         end
         n_cmp++;
         if (arr_valid !== exp_av) begin
            n_err++; $display("FAIL stream_arr_valid cyc %0d: got %b expected %b", cyc, arr_valid, exp_av);
         end
         n_cmp++;
         if (Po !== exp_po) begin
            n_err++; $display("FAIL stream_Po: got %0h expected %0h", Po, exp_po);
         end
         if (win_valid === 1'b1) win_count++;
         cyc++;
      end
      px_valid = 1'b0;
      n_cmp++;
      if (p != NPX) begin
         n_err++; $display("FAIL stream_timeout: got %0d pixels expected %0d", p, NPX);
      end
      // Drain: arr_valid must keep shifting after frame_done.
      for (int k = 0; k < LAT + 3; k++) begin
         tick();
         hist.push_back(1'b0);
         exp_av = hist.pop_front();
         n_cmp++;
         if (arr_valid !== exp_av || win_valid !== 1'b0) begin
            n_err++; $display("FAIL drain cyc %0d: got arr_valid=%b win_valid=%b expected %b/0", k, arr_valid, win_valid, exp_av);
         end
         n_cmp++;
         if (px_ready !== 1'b0 || dbg_state !== IDLE) begin
            n_err++; $display("FAIL drain_idle: got px_ready=%b state=%0d expected 0/IDLE", px_ready, dbg_state);
         end
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (get_wo(i) !== exp_w[i]) begin
            n_err++; $display("FAIL retain_Wo%0d: got %0h expected %0h", i, get_wo(i), exp_w[i]);
         end
      end
   endtask

   task automatic test_window();
      test_weight_load(1'b0);
      run_frame(0);
      n_cmp++;
      if (win_count != ROWS * (IMG_W - 4)) begin
         n_err++; $display("FAIL window_count: got %0d expected %0d", win_count, ROWS * (IMG_W - 4));
      end
   endtask

   task automatic test_bubbles_latency();
      test_weight_load(1'b1);
      run_frame(1);
      test_weight_load(1'b1);
      run_frame(2);
   endtask

   task automatic test_reset_mid();
      test_weight_load(1'b1);
      for (int i = 0; i < IMG_W - 1; i++) begin
         px_valid = 1'b1;
         px_data  = M'($urandom);
         tick();
      end
      px_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({Wo0, Wo1, Wo2, Wo3, Wo4, Io0, Io1, Io2, Io3, Io4, Po} !== '0) begin
         n_err++; $display("FAIL midreset_data: got nonzero data outputs, expected all 0");
      end
      tick();
      n_cmp++;
      if ({w_ready, px_ready, win_valid, arr_valid, row_done, frame_done} !== 6'b0) begin
         n_err++;
         $display("FAIL midreset_flags: got %b expected 000000",
                  {w_ready, px_ready, win_valid, arr_valid, row_done, frame_done});
      end
      n_cmp++;
      if (dbg_state !== IDLE) begin
         n_err++; $display("FAIL midreset_state: got %0d expected %0d", dbg_state, IDLE);
      end
      rst = 1'b1;
      tick();
      exp_po = '0;
      test_weight_load(1'b1);
      run_frame(2);
   endtask

   initial begin
      test_reset();
      test_window();
      test_bubbles_latency();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pe_row_feeder.md
# pe_row_feeder

Input-side driver for the five-tap processing-element row. It loads one filter row of five weights, plus an optional bias, over a valid/ready port. It then accepts a raster stream of image pixels and presents a sliding 5-pixel window, the weights and the partial-sum seed on the row's Wi/Ii/Pi inputs. It also generates a delayed valid marking when the row's Po output carries a finished dot product. It sits between the image/weight memories and one PE row, and is the transmitter for that row's consumer interface.

## Interface
Parameters:
- M, 32, data width of weights, pixels and partial sums.
- N, 0, fractional bits; carried for consistency with the PE row, no arithmetic is done here.
- IMG_W, 32, pixels per image row (≥ 5).
- ROWS, 28, image rows per frame (≥ 1).
- PE_LAT, 1, register stages per PE; the full row latency is 5·PE_LAT.

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that begins a weight load; honoured only in IDLE.
- w_valid, in, 1, weight word valid.
- w_data, in, M, weight word; tap 0 is sent first.
- w_ready, out, 1, high only in LOAD_W.
- px_valid, in, 1, pixel valid.
- px_data, in, M, pixel, raster order.
- px_ready, out, 1, high only in STREAM.
- Wo0..Wo4, out, M each, weights to PE taps 0..4; held stable in STREAM.
- Io0..Io4, out, M each, window; Io0 is the oldest pixel and Io4 the newest.
- Po, out, M, partial-sum seed to the PE row.
- win_valid, out, 1, the current Io0..Io4 form a complete window.
- arr_valid, out, 1, win_valid delayed 5·PE_LAT cycles; qualifies the row's Po output.
- row_done, out, 1, one-cycle pulse after the last pixel of a row.
- frame_done, out, 1, one-cycle pulse after the last pixel of the last row.

## Operation
- States:
  - IDLE → LOAD_W on start.
  - LOAD_W → STREAM after the last weight handshake: the 5th, or the 6th with bias.
  - STREAM → IDLE after pixel IMG_W·ROWS is accepted.
- A handshake occurs when valid && ready in the same cycle.
- LOAD_W:
  - Each weight handshake writes w_data into Wo[wcnt]; wcnt counts 0..4.
  - Weights are retained across frames until the next load.
- STREAM:
  - Each pixel handshake shifts the window: Io0←Io1 … Io3←Io4, Io4←px_data.
  - col counts 0..IMG_W-1 and row counts 0..ROWS-1.
  - win_valid is high in the cycle after the accepted pixel with col ≥ 4. This gives IMG_W-4 windows per row.
  - When col wraps (end of row):
    - row_done pulses.
    - Io0..Io4 clear to 0.
    - win_valid stays low until 5 more pixels of the new row are accepted.
    - Windows never straddle rows.
- Idle cycles (px_valid low) insert bubbles: win_valid is low in the following cycle and the window holds.
- A start pulse in LOAD_W or STREAM is ignored.
- Once streaming begins, w_valid is ignored (w_ready low).
- There is no output back-pressure; the PE row always accepts.
- arr_valid is a shift register of depth 5·PE_LAT fed by win_valid. It keeps shifting in every state, so in-flight results drain after frame_done.

## Timing
- Reset values:
  - All outputs are 0, including Wo*, Io*, Po and every valid/pulse.
  - State is IDLE and all counters are 0.
- w_ready and px_ready are registered state decodes, high from the first cycle in their state.
- Pixel accepted at edge t: Io*/win_valid update at edge t+1, and arr_valid follows at t+1+5·PE_LAT.
- row_done and frame_done are asserted in the same cycle as the win_valid of the row's last window.
- Reset asserted mid-operation clears everything immediately, including the arr_valid pipeline and the weights.

## Configuration
- FEEDER_BIAS_EN:
  - Defined: LOAD_W takes 6 words, and the 6th is latched into a bias register that drives Po.
  - Undefined: LOAD_W takes 5 words and Po is constant 0.

## Structure
- A shared package holds:
  - the state enum (IDLE, LOAD_W, STREAM);
  - the tap count constant K=5;
  - the width helper for the col/row counters, $clog2(IMG_W) and $clog2(ROWS).
- One sub-module, valid_delay (parameter DEPTH, 1-bit shift line with async active-low reset), implements arr_valid.

## Test plan
- Reset: rst low mid-stream → the next cycle shows all outputs 0, state IDLE and w_ready=0.
- Weight load: start, then w_data 1,2,3,4,5 with w_valid held high → w_ready high for 5 cycles, Wo0..Wo4=1..5, then px_ready rises.
- Window: IMG_W=8, pixels 10..17:
  - first win_valid after pixel 14, with Io0..Io4=10..14;
  - 4 windows in total; the last is 13..17 with row_done in the same cycle.
- Row boundary: the 2nd row's pixels 20..27 → no win_valid until pixel 24 is accepted, and no window mixes 1x and 2x values.
- Bubbles and latency:
  - px_valid toggled 1/0 → one window per 2 cycles;
  - with PE_LAT=1, arr_valid mirrors win_valid exactly 5 cycles later, including after frame_done.
- Bias, with FEEDER_BIAS_EN defined: load 1..5 then 7 → Po=7 throughout STREAM, and start during STREAM is ignored. Undefined: Po stays 0.
